fp_soc_key_poller: RTL and testbench

FP_SOC_KEY_POLLER -- requirements
Module: fp_soc_key_poller

---
 rtl/fp_soc_key_pkg.sv | 25 ++
 rtl/fp_soc_key_debounce.sv | 66 ++++++
 rtl/fp_soc_key_poller.sv | 103 ++++++++++
 tb/tb_fp_soc_key_poller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_soc_key_pkg.sv
// Shared types and constants for the key PIO poller: FSM state encoding,
// Avalon read timing and the key sampling helper.
package fp_soc_key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      UPDATE  = 2'd3
   } poll_state_e;

   localparam int         READ_LATENCY      = 1;
   localparam logic [1:0] KEY_PIO_DATA_ADDR = 2'd0;
   localparam int         NUM_KEYS          = 2;
   localparam int         DEB_CNT_W         = 4;

   // READ + CAPTURE (READ_LATENCY cycles) + UPDATE + the final IDLE count cycle.
   localparam int POLL_OVERHEAD = READ_LATENCY + 3;

   function automatic logic [NUM_KEYS-1:0] key_sample(input logic [NUM_KEYS-1:0] raw,
                                                      input logic            active_low);
      return active_low ? ~raw : raw;
   endfunction

endpackage

// File: rtl/fp_soc_key_debounce.sv
// Single-key debouncer: a debounced level that toggles after DEBOUNCE_SAMPLES
// consecutive polls disagree with it, with one-cycle press/release pulses.
module fp_soc_key_debounce
   import fp_soc_key_pkg::*;
#(
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic update_i,
   input  logic sample_i,
   output logic state_o,
   output logic press_o,
   output logic release_o
);

   localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_SAMPLES - 1);

   logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
   logic                 state_q, state_d;
   logic                 press_q, press_d;
   logic                 release_q, release_d;
   logic                 differ;

   assign differ = sample_i ^ state_q;

   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      cnt_d     = cnt_q;
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (update_i) begin
         if (!differ) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            state_d   = sample_i;
            press_d   = sample_i;
            release_d = ~sample_i;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         state_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign state_o   = state_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/fp_soc_key_poller.sv
// Periodic Avalon-MM poller for a two-key PIO: reads the key port every
// POLL_DIV cycles and debounces each key independently.
module fp_soc_key_poller
   import fp_soc_key_pkg::*;
#(
   parameter int POLL_DIV         = 50000,
   parameter int DEBOUNCE_SAMPLES = 4,
   parameter int KEY_ACTIVE_LOW   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   output logic [1:0]          avm_address,
   output logic                avm_read,
   input  logic [31:0]         avm_readdata,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                poll_done
);

   localparam int               CNT_W    = $clog2(POLL_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - POLL_OVERHEAD);

   poll_state_e         state_q, state_d;
   logic [CNT_W-1:0]    poll_cnt_q, poll_cnt_d;
   logic [NUM_KEYS-1:0] sample_q, sample_d;
   logic                poll_done_q;
   logic                capture;
   logic                update;
   logic                unused_readdata_hi;

   assign unused_readdata_hi = ^avm_readdata[31:NUM_KEYS];

   always_comb begin
      state_d    = state_q;
      poll_cnt_d = poll_cnt_q;
      capture    = 1'b0;
      update     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // The count parks at its last value while polling is disabled.
            if (poll_cnt_q == CNT_LAST) begin
               if (enable) state_d = READ;
            end else begin
               poll_cnt_d = poll_cnt_q + 1'b1;
            end
         end
         READ:    state_d = CAPTURE;
         CAPTURE: begin
            capture = 1'b1;
            state_d = UPDATE;
         end
         UPDATE: begin
            update     = 1'b1;
            poll_cnt_d = '0;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         poll_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
      end
   end

   assign sample_d = key_sample(avm_readdata[NUM_KEYS-1:0], KEY_ACTIVE_LOW != 0);

   // Read data is valid READ_LATENCY cycles after the strobe, i.e. in CAPTURE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_q    <= '0;
         poll_done_q <= 1'b0;
      end else begin
         poll_done_q <= capture;
         if (capture) sample_q <= sample_d;
      end
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      fp_soc_key_debounce #(
         .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
      ) u_debounce (
         .clk      (clk),
         .reset    (reset),
         .update_i (update),
         .sample_i (sample_q[k]),
         .state_o  (key_state[k]),
         .press_o  (key_press[k]),
         .release_o(key_release[k])
      );
   end

   assign avm_read    = (state_q == READ);
   assign avm_address = KEY_PIO_DATA_ADDR;
   assign poll_done   = poll_done_q;

endmodule

// File: tb/tb_fp_soc_key_poller.sv
// Self-checking bench for fp_soc_key_poller with POLL_DIV=8, DEBOUNCE_SAMPLES=3.
module tb_fp_soc_key_poller;

   localparam int POLL_DIV = 8;
   localparam int DEB      = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic [1:0]  key_state;
   logic [1:0]  key_press;
   logic [1:0]  key_release;
   logic        poll_done;

   fp_soc_key_poller #(
      .POLL_DIV        (POLL_DIV),
      .DEBOUNCE_SAMPLES(DEB),
      .KEY_ACTIVE_LOW  (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .avm_address (avm_address),
      .avm_read    (avm_read),
      .avm_readdata(avm_readdata),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .poll_done   (poll_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] word;
      logic [1:0]  st;
      logic [1:0]  pr;
      logic [1:0]  rl;
   } vec_t;

   typedef struct {
      logic [1:0] st;
      logic [1:0] pr;
      logic [1:0] rl;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   last_read = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_read(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (avm_read === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One full poll: answer the read, then compare the update result from the scoreboard.
   task automatic do_poll(input string tag, input logic [31:0] word, input logic [1:0] st,
                          input logic [1:0] pr, input logic [1:0] rl, input int gap,
                          input bit drop_en);
      bit   ok;
      exp_t e;
      wait_read(ok);
      check($sformatf("%s read_seen", tag), 32'(ok), 32'd1);
      if (!ok) return;
      if (gap > 0) check($sformatf("%s read_gap", tag), 32'(cyc - last_read), 32'(gap));
      last_read = cyc;
      check($sformatf("%s avm_address", tag), 32'(avm_address), 32'd0);
      sb.push_back('{st, pr, rl});
      avm_readdata = ~word;
      if (drop_en) enable = 1'b0;
      @(negedge clk);
      check($sformatf("%s read_one_cycle", tag), 32'(avm_read), 32'd0);
      check($sformatf("%s done_early", tag), 32'(poll_done), 32'd0);
      avm_readdata = word;
      @(negedge clk);
      check($sformatf("%s poll_done", tag), 32'(poll_done), 32'd1);
      avm_readdata = ~word;
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s key_state", tag), 32'(key_state), 32'(e.st));
      check($sformatf("%s key_press", tag), 32'(key_press), 32'(e.pr));
      check($sformatf("%s key_release", tag), 32'(key_release), 32'(e.rl));
      check($sformatf("%s done_pulse", tag), 32'(poll_done), 32'd0);
      @(negedge clk);
      check($sformatf("%s press_pulse", tag), 32'(key_press), 32'd0);
      check($sformatf("%s release_pulse", tag), 32'(key_release), 32'd0);
      check($sformatf("%s state_hold", tag), 32'(key_state), 32'(e.st));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int reads;
      int dones;

      // Key 0 pressed 3 polls, then released 3 polls.
      vq.push_back('{32'hFFFF_FFFE, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFE, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFE, 2'b01, 2'b01, 2'b00});
      vq.push_back('{32'hFFFF_FFFF, 2'b01, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFF, 2'b01, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFF, 2'b00, 2'b00, 2'b01});
      // Bounce: pressed 2, released 1, pressed 3.
      vq.push_back('{32'h0000_0002, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0002, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFF, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0002, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0002, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0002, 2'b01, 2'b01, 2'b00});
      vq.push_back('{32'hFFFF_FFFF, 2'b01, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFF, 2'b01, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFF, 2'b00, 2'b00, 2'b01});
      // Both keys together, then both released.
      vq.push_back('{32'h0000_0000, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0000, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0000, 2'b11, 2'b11, 2'b00});
      vq.push_back('{32'h0000_0003, 2'b11, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0003, 2'b11, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0003, 2'b00, 2'b00, 2'b11});
      // Upper bits set must behave like all-zero data.
      vq.push_back('{32'hFFFF_FFFC, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFC, 2'b00, 2'b00, 2'b00});
      vq.push_back('{32'hFFFF_FFFC, 2'b11, 2'b11, 2'b00});
      // Key 0 releases while key 1 stays held.
      vq.push_back('{32'h0000_0001, 2'b11, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0001, 2'b11, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0001, 2'b10, 2'b00, 2'b01});
      // Opposite transitions on the two keys in the same update.
      vq.push_back('{32'h0000_0002, 2'b10, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0002, 2'b10, 2'b00, 2'b00});
      vq.push_back('{32'h0000_0002, 2'b01, 2'b01, 2'b10});

      reset        = 1'b1;
      enable       = 1'b1;
      avm_readdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check("rst key_state", 32'(key_state), 32'd0);
      check("rst key_press", 32'(key_press), 32'd0);
      check("rst key_release", 32'(key_release), 32'd0);
      check("rst poll_done", 32'(poll_done), 32'd0);
      check("rst avm_read", 32'(avm_read), 32'd0);
      check("rst avm_address", 32'(avm_address), 32'd0);
      reset     = 1'b0;
      last_read = cyc;

      foreach (vq[i])
         do_poll($sformatf("vec%0d", i), vq[i].word, vq[i].st, vq[i].pr, vq[i].rl,
                 (i == 0) ? POLL_DIV - 3 : POLL_DIV, 1'b0);

      // Reset in the middle of a READ clears everything immediately.
      wait_read(ok);
      check("mid_rst read_seen", 32'(ok), 32'd1);
      avm_readdata = 32'h0000_0000;
      reset = 1'b1;
      #1;
      check("mid_rst avm_read", 32'(avm_read), 32'd0);
      check("mid_rst key_state", 32'(key_state), 32'd0);
      check("mid_rst poll_done", 32'(poll_done), 32'd0);
      repeat (2) @(negedge clk);
      check("mid_rst no_done", 32'(poll_done), 32'd0);
      reset     = 1'b0;
      last_read = cyc;

      // Enable dropped during READ: the poll completes, then polling stops.
      do_poll("en_drop", 32'hFFFF_FFFF, 2'b00, 2'b00, 2'b00, POLL_DIV - 3, 1'b1);
      reads = 0;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (avm_read === 1'b1) reads++;
         if (poll_done === 1'b1) dones++;
      end
      check("disabled reads", 32'(reads), 32'd0);
      check("disabled dones", 32'(dones), 32'd0);

      // Re-enable: the held count starts a READ on the very next edge.
      enable    = 1'b1;
      last_read = cyc;
      do_poll("reen0", 32'h0000_0000, 2'b00, 2'b00, 2'b00, 1, 1'b0);
      do_poll("reen1", 32'h0000_0000, 2'b00, 2'b00, 2'b00, POLL_DIV, 1'b0);
      do_poll("reen2", 32'h0000_0000, 2'b11, 2'b11, 2'b00, POLL_DIV, 1'b0);

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
